// File: rtl/commu_tx485_if.sv
// Packer-to-transmitter byte stream.
//   pk_data : packed byte, valid while pk_vld is high
//   pk_vld  : one-cycle write strobe
//   pk_frm  : high for the duration of one packer frame
// master = packer side, slave = commu_tx485.
interface commu_tx485_if;
  logic [7:0] pk_data;
  logic       pk_vld;
  logic       pk_frm;

  modport master (output pk_data, output pk_vld, output pk_frm);
  modport slave  (input  pk_data, input  pk_vld, input  pk_frm);
endinterface

// File: rtl/commu_tx485.sv
// Half-duplex RS-485 frame transmitter: buffers packer bytes in a FIFO and
// sends them as 8N1 UART, wrapping each frame in lead/tail driver-enable guards.
//   clk_sys : system clock          rst_n   : async active-low reset
//   pk      : packer byte stream (slave modport)
//   tx      : UART serial out, idle high
//   te / re : driver enable / receiver disable (re mirrors te)
//   busy    : transmitter not idle  ovf     : byte dropped on full FIFO (pulse)
//   frm_cnt : completed frames, wraps at 16 bits
module commu_tx485 #(
  parameter int unsigned BAUD_DIV   = 434,
  parameter int unsigned GUARD_BITS = 2,
  parameter int unsigned FIFO_AW    = 6
) (
  input  logic         clk_sys,
  input  logic         rst_n,
  commu_tx485_if.slave pk,
  output logic         tx,
  output logic         te,
  output logic         re,
  output logic         busy,
  output logic         ovf,
  output logic [15:0]  frm_cnt
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned PTR_W = FIFO_AW + 1;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned BIT_W = 16;
  localparam logic [CNT_W-1:0] BAUD_LAST  = CNT_W'(BAUD_DIV - 1);
  localparam logic [BIT_W-1:0] GUARD_LAST = BIT_W'(GUARD_BITS - 1);
  localparam logic [BIT_W-1:0] DATA_LAST  = BIT_W'(7);

  typedef enum logic [2:0] {
    S_IDLE, S_LEAD, S_START, S_DATA, S_STOP, S_GAP, S_TAIL
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_d;
  logic             frm_done;
  logic             counting, bit_tick;

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             fifo_empty, fifo_full, wr_en, rd_en;

  logic             frm_q, fo;

  // FIFO status; a write into a full FIFO is still taken when a pop happens alongside it
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                      (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign wr_en      = pk.pk_vld && (!fifo_full || rd_en);

  // FIFO storage (no reset needed; pointers define validity)
  always_ff @(posedge clk_sys) begin
    if (wr_en) mem[wr_ptr[FIFO_AW-1:0]] <= pk.pk_data;
  end

  // FIFO pointers and overflow pulse
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      ovf <= pk.pk_vld && !wr_en;
    end
  end

  // Frame-open flag from edges of pk_frm against its registered copy
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      frm_q <= 1'b0;
      fo    <= 1'b0;
    end else begin
      frm_q <= pk.pk_frm;
      if (pk.pk_frm && !frm_q)      fo <= 1'b1;
      else if (!pk.pk_frm && frm_q) fo <= 1'b0;
    end
  end

  // Baud counter runs only in bit-timed states; GAP and IDLE hold it at zero
  assign counting = (state_q == S_LEAD) || (state_q == S_START) || (state_q == S_DATA) ||
                    (state_q == S_STOP) || (state_q == S_TAIL);
  assign bit_tick = counting && (baud_q == BAUD_LAST);

  // Next-state, FIFO pop, shift register and line value
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    rd_en    = 1'b0;
    frm_done = 1'b0;
    tx_d     = 1'b1;
    baud_d   = '0;
    bit_d    = '0;

    unique case (state_q)
      S_IDLE:  if (!fifo_empty) state_d = S_LEAD;
      S_LEAD:  if (bit_tick && bit_q == GUARD_LAST) state_d = S_START;
      S_START: if (bit_tick) state_d = S_DATA;
      S_DATA: begin
        if (bit_tick) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == DATA_LAST) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_tick) begin
          if (!fifo_empty) state_d = S_START;
          else if (fo)     state_d = S_GAP;
          else             state_d = S_TAIL;
        end
      end
      S_GAP: begin
        if (!fifo_empty) state_d = S_START;
        else if (!fo)    state_d = S_TAIL;
      end
      S_TAIL: begin
        // a new byte during the tail reopens transmission without dropping te
        if (!fifo_empty) begin
          state_d = S_START;
        end else if (bit_tick && bit_q == GUARD_LAST) begin
          state_d  = S_IDLE;
          frm_done = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Pop the head into the shifter on every entry to START
    if (state_d == S_START && state_q != S_START) begin
      rd_en   = 1'b1;
      shift_d = mem[rd_ptr[FIFO_AW-1:0]];
    end

    // Counters restart on each state entry
    if (state_d == state_q) begin
      if (counting && !bit_tick) baud_d = baud_q + CNT_W'(1);
      bit_d = bit_tick ? bit_q + BIT_W'(1) : bit_q;
    end

    if (state_d == S_START)     tx_d = 1'b0;
    else if (state_d == S_DATA) tx_d = shift_d[0];
  end

  // State and registered outputs
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx      <= 1'b1;
      te      <= 1'b0;
      busy    <= 1'b0;
      frm_cnt <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx      <= tx_d;
      te      <= (state_d != S_IDLE);
      busy    <= (state_d != S_IDLE);
      if (frm_done) frm_cnt <= frm_cnt + 16'd1;
    end
  end

  assign re = te;

endmodule
